g2_chain_walker: RTL and testbench
==================================

// Module: g2_chain_walker
// PURPOSE
//  Walks one G2 hash-bucket chain per request. Drives search_index/tupleData into search_G2table and
//  consumes its registered match/ruleID/next_index, following next_index until hit, end of chain or hop limit.
//  Sits between the tuple hash stage (upstream, supplies start index) and the priority/result merge stage (downstream).
// PARAMETERS
//  LOOKUP_LAT   2       cycles from search_index driven to lk_* valid (ROM read + compare register)
//  MAX_HOPS     8       max lookups per request before forced miss (1..15)
//  NULL_INDEX   11'h7FF next_index value marking end of chain
// PORTS
//  clk            in   1    clock, all logic on posedge
//  rst            in   1    synchronous, active-high reset
//  req_valid      in   1    request present
//  req_ready      out  1    walker accepts request (IDLE only)
//  req_index      in   11   chain head index from hash stage
//  req_tuple      in   104  {proto[103:96],rsvd,dstPort/srcPort[79:64],dstIP[63:32],srcIP[31:0]}
//  search_index   out  11   address to search_G2table
//  tupleData      out  104  latched req_tuple, held for whole walk
//  lk_match       in   1    lookup hit, sampled only in WAIT at return cycle
//  lk_ruleID      in   11   rule ID of hit entry
//  lk_next_index  in   11   next chain entry
//  rsp_valid      out  1    result present
//  rsp_ready      in   1    downstream accepts result
//  rsp_match      out  1    1 = rule found
//  rsp_ruleID     out  11   matched rule, 0 on miss
//  rsp_hops       out  4    lookups performed (0..MAX_HOPS)
//  rsp_overflow   out  1    walk ended by hop limit, not NULL
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after reset deasserts; rsp_valid=0, rsp_match=0, rsp_ruleID=0,
//    rsp_hops=0, rsp_overflow=0, search_index=NULL_INDEX, tupleData=0, hop/wait counters 0.
//  - FSM IDLE->ISSUE->WAIT->(ISSUE|DONE)->IDLE; one request in flight, no pipelining across requests.
//  - IDLE: req_ready=1. On req_valid: latch tuple, hops=0. If req_index==NULL_INDEX -> DONE miss, hops 0,
//    no lookup issued. Else search_index<=req_index, ->ISSUE.
//  - ISSUE (1 cycle): hops++; wait counter=LOOKUP_LAT-1; ->WAIT. search_index stable.
//  - WAIT: count down; when 0 sample lk_*. Priority: lk_match -> DONE hit (ruleID captured, ignores next_index);
//    else lk_next_index==NULL_INDEX -> DONE miss; else hops==MAX_HOPS -> DONE miss, rsp_overflow=1;
//    else search_index<=lk_next_index, ->ISSUE.
//  - Latency per hop = LOOKUP_LAT+1 cycles; single-entry hit: rsp_valid LOOKUP_LAT+2 cycles after accept.
//  - DONE: rsp_valid=1, rsp_* held stable until rsp_valid&&rsp_ready; then ->IDLE, rsp_valid=0 next cycle.
//    req_ready=0 in DONE (no accept same cycle as response handshake).
//  - lk_* outside the sample cycle are ignored (lookup stage match is not self-clearing).
//  - Self-loop chain (next_index==current) terminates via MAX_HOPS overflow.
//  - rst mid-walk: walk aborted, no response, outstanding lookup result discarded.
// CONFIGURATION
//  G2_WALK_STATS_EN defined: extra outputs stat_lookups[31:0] (total lookups issued, wraps at 2^32),
//  stat_max_hops[3:0] (largest rsp_hops seen), stat_overflows[15:0] (saturating); all cleared by rst.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  - g2_pkg: INDEX_W=11, RULEID_W=11, TUPLE_W=104, NULL_INDEX, tuple field offsets, FSM state encoding.
//  - Single module; wait counter inline. No sub-module.
// TESTING
//  1 Head NULL: req_index=11'h7FF -> rsp_valid next cycle, match=0, hops=0, no search_index change.
//  2 Hit on head: index 5, lk_match=1 ruleID=42 -> rsp match=1 ruleID=42 hops=1 at accept+4 (LAT=2).
//  3 Chain 5->9->NULL, hit at 9 ruleID=7 -> search_index 5 then 9, rsp hops=2 ruleID=7.
//  4 Chain 5->9->NULL, no match -> rsp match=0 ruleID=0 hops=2 overflow=0.
//  5 Self-loop 3->3, MAX_HOPS=8 -> rsp match=0 hops=8 overflow=1.
//  6 rsp_ready low 5 cycles then high; rst pulse during WAIT -> rsp held stable; after rst IDLE, no rsp.

Source files
------------

// File: rtl/g2_pkg.sv
// Shared widths, end-of-chain marker, tuple field offsets and walker FSM encoding for the G2 chain walker.
package g2_pkg;

    localparam int INDEX_W  = 11;
    localparam int RULEID_W = 11;
    localparam int TUPLE_W  = 104;
    localparam int HOPS_W   = 4;

    localparam logic [INDEX_W-1:0] G2_NULL_INDEX = 11'h7FF;

    // Tuple layout: {proto, rsvd, ports, dst_ip, src_ip}
    localparam int SRC_IP_LSB = 0;
    localparam int DST_IP_LSB = 32;
    localparam int PORTS_LSB  = 64;
    localparam int PROTO_LSB  = 96;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } g2_state_e;

endpackage

// File: rtl/g2_chain_walker.sv
// Walks one G2 hash-bucket chain per request until hit, end of chain or hop limit.
// Optional statistics outputs are built when G2_WALK_STATS_EN is defined.
module g2_chain_walker
    import g2_pkg::*;
#(
    parameter int                 LOOKUP_LAT = 2,
    parameter int                 MAX_HOPS   = 8,
    parameter logic [INDEX_W-1:0] NULL_INDEX = G2_NULL_INDEX
) (
    input  logic                clk,
    input  logic                rst,
    // Handshakes: a transfer happens on a posedge where valid && ready; valid never waits on ready.
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [INDEX_W-1:0]  req_index,
    input  logic [TUPLE_W-1:0]  req_tuple,
    output logic [INDEX_W-1:0]  search_index,
    output logic [TUPLE_W-1:0]  tupleData,
    input  logic                lk_match,
    input  logic [RULEID_W-1:0] lk_ruleID,
    input  logic [INDEX_W-1:0]  lk_next_index,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_match,
    output logic [RULEID_W-1:0] rsp_ruleID,
    output logic [HOPS_W-1:0]   rsp_hops,
    output logic                rsp_overflow,
`ifdef G2_WALK_STATS_EN
    output logic [31:0]         stat_lookups,
    output logic [HOPS_W-1:0]   stat_max_hops,
    output logic [15:0]         stat_overflows,
`endif
    output g2_state_e           dbg_state
);

    localparam logic [3:0]        WAIT_INIT = 4'(LOOKUP_LAT - 1);
    localparam logic [HOPS_W-1:0] HOP_LIMIT = HOPS_W'(MAX_HOPS);

    g2_state_e  state, state_n;
    logic [3:0] wait_cnt;
    logic       wait_zero;
    logic       at_limit;
    logic       overflow_end;

    assign wait_zero    = (wait_cnt == 4'd0);
    assign at_limit     = (rsp_hops == HOP_LIMIT);
    // Lookup result is only meaningful on the last WAIT cycle; lk_* is stale otherwise.
    assign overflow_end = (state == ST_WAIT) && wait_zero && !lk_match &&
                          (lk_next_index != NULL_INDEX) && at_limit;
    assign dbg_state    = state;

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = (req_index == NULL_INDEX) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT: begin
                if (wait_zero) begin
                    if (lk_match || (lk_next_index == NULL_INDEX) || at_limit) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            search_index <= NULL_INDEX;
            tupleData    <= '0;
            rsp_match    <= 1'b0;
            rsp_ruleID   <= '0;
            rsp_hops     <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        tupleData    <= req_tuple;
                        rsp_hops     <= '0;
                        rsp_match    <= 1'b0;
                        rsp_ruleID   <= '0;
                        rsp_overflow <= 1'b0;
                        if (req_index != NULL_INDEX) begin
                            search_index <= req_index;
                        end
                    end
                end
                ST_ISSUE: begin
                    rsp_hops <= rsp_hops + 1'b1;
                    wait_cnt <= WAIT_INIT;
                end
                ST_WAIT: begin
                    if (!wait_zero) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (lk_match) begin
                        rsp_match  <= 1'b1;
                        rsp_ruleID <= lk_ruleID;
                    end else if (lk_next_index == NULL_INDEX) begin
                        rsp_match <= 1'b0;
                    end else if (at_limit) begin
                        rsp_overflow <= 1'b1;
                    end else begin
                        search_index <= lk_next_index;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef G2_WALK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups   <= '0;
            stat_max_hops  <= '0;
            stat_overflows <= '0;
        end else begin
            if (state == ST_ISSUE) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if ((state == ST_DONE) && (rsp_hops > stat_max_hops)) begin
                stat_max_hops <= rsp_hops;
            end
            if (overflow_end && (stat_overflows != 16'hFFFF)) begin
                stat_overflows <= stat_overflows + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_g2_chain_walker.sv
// Bench for g2_chain_walker: table-driven chain walks against a modelled two-cycle lookup table, plus
// back-pressure and mid-walk reset sequences.
module tb_g2_chain_walker;
    import g2_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [10:0]   req_index = 11'h7FF;
    logic [103:0]  req_tuple = '0;
    logic [10:0]   search_index;
    logic [103:0]  tupleData;
    logic          lk_match;
    logic [10:0]   lk_ruleID;
    logic [10:0]   lk_next_index;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_match;
    logic [10:0]   rsp_ruleID;
    logic [3:0]    rsp_hops;
    logic          rsp_overflow;
    g2_state_e     dbg_state;

    always #5 clk = ~clk;

    g2_chain_walker dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tuple(req_tuple),
        .search_index(search_index), .tupleData(tupleData),
        .lk_match(lk_match), .lk_ruleID(lk_ruleID), .lk_next_index(lk_next_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_match(rsp_match),
        .rsp_ruleID(rsp_ruleID), .rsp_hops(rsp_hops), .rsp_overflow(rsp_overflow),
        .dbg_state(dbg_state)
    );

    // Lookup table model: registered address, then registered read -> 2 cycles index-to-result.
    logic        tbl_match [2048];
    logic [10:0] tbl_rule  [2048];
    logic [10:0] tbl_next  [2048];
    logic [10:0] lk_addr;

    always @(posedge clk) begin
        lk_addr       <= search_index;
        lk_match      <= tbl_match[lk_addr];
        lk_ruleID     <= tbl_rule[lk_addr];
        lk_next_index <= tbl_next[lk_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every accepted response is popped and compared against the expected queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 128'd1, 128'd0);
            end else begin
                check("rsp_fields", {111'd0, rsp_match, rsp_ruleID, rsp_hops, rsp_overflow},
                      {111'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [10:0] head;
        logic [10:0] n1;
        int          hit_at;
        logic [10:0] rule;
        logic        exp_match;
        logic [10:0] exp_rule;
        logic [3:0]  exp_hops;
        logic        exp_ovf;
        logic [10:0] exp_si;
    } vec_t;

    vec_t vecs[9];

    task automatic load_chain(input vec_t v);
        if (v.head != 11'h7FF) begin
            tbl_match[v.head] = (v.hit_at == 1);
            tbl_rule[v.head]  = v.rule;
            tbl_next[v.head]  = v.n1;
            if (v.n1 != 11'h7FF && v.n1 != v.head) begin
                tbl_match[v.n1] = (v.hit_at == 2);
                tbl_rule[v.n1]  = v.rule;
                tbl_next[v.n1]  = 11'h7FF;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        logic [127:0] tmp;
        logic [103:0] t;
        int k;
        int exp_lat;
        bit got;
        tmp = {$urandom, $urandom, $urandom, $urandom};
        t = tmp[103:0];
        exp_lat = (v.exp_hops == 0) ? 1 : 1 + 3 * int'(v.exp_hops);
        load_chain(v);
        @(negedge clk);
        if (hold > 0) rsp_ready = 1'b0;
        check("req_ready_idle", {127'd0, req_ready}, 128'd1);
        req_valid = 1'b1;
        req_index = v.head;
        req_tuple = t;
        exp_q.push_back({v.exp_match, v.exp_rule, v.exp_hops, v.exp_ovf});
        k = 0;
        got = 0;
        while (k < 60 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req_valid = 1'b0;
                check("search_index_head", {117'd0, search_index}, {117'd0, v.exp_si});
            end
            if (rsp_valid) got = 1;
        end
        check("rsp_latency", 128'(k), 128'(exp_lat));
        check("tupleData", {24'd0, tupleData}, {24'd0, t});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", {127'd0, rsp_valid}, 128'd1);
                check("hold_stable", {111'd0, rsp_match, rsp_ruleID, rsp_hops, rsp_overflow},
                      {111'd0, v.exp_match, v.exp_rule, v.exp_hops, v.exp_ovf});
                check("hold_req_ready", {127'd0, req_ready}, 128'd0);
            end
            @(posedge clk);
            #2 rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid_drop", {127'd0, rsp_valid}, 128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        for (int i = 0; i < 2048; i++) begin
            tbl_match[i] = 1'b0;
            tbl_rule[i]  = 11'd0;
            tbl_next[i]  = 11'h7FF;
        end
        vecs[0] = '{11'h7FF, 11'h7FF, 0, 11'h000, 1'b0, 11'h000, 4'd0, 1'b0, 11'h7FF};
        vecs[1] = '{11'd5,   11'h7FF, 1, 11'd42,  1'b1, 11'd42,  4'd1, 1'b0, 11'd5};
        vecs[2] = '{11'd100, 11'h7FF, 0, 11'h123, 1'b0, 11'h000, 4'd1, 1'b0, 11'd100};
        vecs[3] = '{11'd5,   11'd9,   2, 11'd7,   1'b1, 11'd7,   4'd2, 1'b0, 11'd5};
        vecs[4] = '{11'd5,   11'd9,   0, 11'h123, 1'b0, 11'h000, 4'd2, 1'b0, 11'd5};
        vecs[5] = '{11'd3,   11'd3,   0, 11'h123, 1'b0, 11'h000, 4'd8, 1'b1, 11'd3};
        vecs[6] = '{11'h7FF, 11'h7FF, 0, 11'h000, 1'b0, 11'h000, 4'd0, 1'b0, 11'd3};
        vecs[7] = '{11'd200, 11'd300, 1, 11'h555, 1'b1, 11'h555, 4'd1, 1'b0, 11'd200};
        vecs[8] = '{11'd0,   11'h7FE, 2, 11'd1,   1'b1, 11'd1,   4'd2, 1'b0, 11'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_req_ready", {127'd0, req_ready}, 128'd1);
        check("reset_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        check("reset_rsp_fields", {111'd0, rsp_match, rsp_ruleID, rsp_hops, rsp_overflow}, 128'd0);
        check("reset_search_index", {117'd0, search_index}, 128'h7FF);
        check("reset_tupleData", {24'd0, tupleData}, 128'd0);
        check("reset_state", {126'd0, dbg_state}, {126'd0, ST_IDLE});

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], 0);
        end

        // Back-pressure: response must hold for 5 cycles with rsp_ready low.
        run_vec(vecs[1], 5);

        // Reset during WAIT: walk aborted, nothing reported.
        load_chain(vecs[3]);
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 11'd5;
        req_tuple = 104'h1234;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_wait", {126'd0, dbg_state}, {126'd0, ST_WAIT});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {126'd0, dbg_state}, {126'd0, ST_IDLE});
        check("midrst_req_ready", {127'd0, req_ready}, 128'd1);
        check("midrst_search_index", {117'd0, search_index}, 128'h7FF);
        check("midrst_hops", {124'd0, rsp_hops}, 128'd0);
        check("midrst_tupleData", {24'd0, tupleData}, 128'd0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("midrst_no_rsp", 128'(bad), 128'd0);

        run_vec(vecs[3], 0);

        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
